// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 hex keypad matrix scanner with per-key debounce and event FIFO
//
// keypad_event_fifo: small synchronous FIFO for key event bytes
//   clk_in, rst_in        clock, synchronous active-high reset
//   s_tvalid/s_tready     push handshake, s_tdata pushed byte
//   m_tvalid/m_tready     pop handshake, m_tdata head byte
//
// keypad_scanner: drives keypad rows, senses columns, debounces, emits press/release bytes
//   clk_in       system clock
//   rst_in       synchronous reset, active-high
//   row_out[3:0] row drive, one-hot active-low (4'hF while in reset)
//   col_in[3:0]  column sense, active-low
//   event_valid  event FIFO non-empty
//   event_ready  consumer accepts the head byte this cycle
//   key_event    {pressed,3'b000,key}; 8'hFF when no event pending
//   key_state    debounced state, bit k = hex key k held
//   overflow     sticky flag: an event was dropped because the FIFO was full

module keypad_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic [WIDTH-1:0] s_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [WIDTH-1:0] m_tdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign m_tvalid = !empty;
  assign m_tdata  = mem[rd_ptr[AW-1:0]];
  assign do_pop   = m_tvalid && m_tready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign s_tready = !full || do_pop;
  assign do_push  = s_tvalid && s_tready;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= s_tdata;
  end

endmodule

module keypad_scanner #(
  parameter int SETTLE_CYCLES  = 8,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic [3:0]  row_out,
  input  logic [3:0]  col_in,
  output logic        event_valid,
  input  logic        event_ready,
  output logic [7:0]  key_event,
  output logic [15:0] key_state,
  output logic        overflow
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_SCANS - 1);

  // Matrix position {row,col} to hex key value.
  function automatic logic [3:0] key_of(input logic [3:0] pos);
    logic [3:0] k;
    k = 4'h0;
    case (pos)
      4'd0:  k = 4'h1;
      4'd1:  k = 4'h2;
      4'd2:  k = 4'h3;
      4'd3:  k = 4'hC;
      4'd4:  k = 4'h4;
      4'd5:  k = 4'h5;
      4'd6:  k = 4'h6;
      4'd7:  k = 4'hD;
      4'd8:  k = 4'h7;
      4'd9:  k = 4'h8;
      4'd10: k = 4'h9;
      4'd11: k = 4'hE;
      4'd12: k = 4'hA;
      4'd13: k = 4'h0;
      4'd14: k = 4'hB;
      default: k = 4'hF;
    endcase
    return k;
  endfunction

  // Scan timing
  logic          running;
  logic [1:0]    row_idx;
  logic [SW-1:0] settle_ctr;
  logic          sample_now;

  // Column synchroniser
  logic [3:0]    col_meta;
  logic [3:0]    col_sync;

  // Debounce state, indexed by matrix position rather than key value
  logic [15:0]   pos_state;
  logic [15:0]   pos_state_nxt;
  logic [DW-1:0] deb_ctr [16];
  logic [DW-1:0] deb_nxt [16];
  logic [3:0]    mask_nxt;
  logic [3:0]    pos_c;

  // Accepted changes of the most recently sampled row, pushed during the next row period
  logic [3:0]    chg_mask;
  logic [1:0]    chg_row;

  logic [1:0]    push_col;
  logic [3:0]    push_pos;
  logic          push_slot;
  logic          push_now;
  logic [7:0]    push_data;
  logic          fifo_ready;
  logic [7:0]    fifo_head;

  // running stays low during reset so the rows float high, and the first
  // cycle out of reset already drives row 0.
  assign row_out    = running ? ~(4'b0001 << row_idx) : 4'hF;
  assign sample_now = running && (settle_ctr == SETTLE_LAST);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      running    <= 1'b0;
      row_idx    <= 2'd0;
      settle_ctr <= '0;
    end else begin
      running <= 1'b1;
      if (running) begin
        if (settle_ctr == SETTLE_LAST) begin
          settle_ctr <= '0;
          row_idx    <= row_idx + 2'd1;
        end else begin
          settle_ctr <= settle_ctr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

  // Debounce the four keys of the row currently driven. A key only changes
  // state after DEBOUNCE_SCANS consecutive disagreeing samples; any agreeing
  // sample restarts the count.
  always_comb begin
    pos_state_nxt = pos_state;
    mask_nxt      = 4'b0000;
    pos_c         = 4'd0;
    for (int i = 0; i < 16; i++) deb_nxt[i] = deb_ctr[i];
    for (int c = 0; c < 4; c++) begin
      pos_c = {row_idx, 2'(c)};
      if (!col_sync[c] == pos_state[pos_c]) begin
        deb_nxt[pos_c] = '0;
      end else if (deb_ctr[pos_c] == DEB_LAST) begin
        pos_state_nxt[pos_c] = !pos_state[pos_c];
        deb_nxt[pos_c]       = '0;
        mask_nxt[c]          = 1'b1;
      end else begin
        deb_nxt[pos_c] = deb_ctr[pos_c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pos_state <= '0;
      chg_mask  <= 4'b0000;
      chg_row   <= 2'd0;
      for (int i = 0; i < 16; i++) deb_ctr[i] <= '0;
    end else if (sample_now) begin
      pos_state <= pos_state_nxt;
      deb_ctr   <= deb_nxt;
      // Every row period ends in a sample, so the previous mask has always
      // been fully pushed (cycles 0..3) before it is overwritten here.
      chg_mask  <= mask_nxt;
      chg_row   <= row_idx;
    end
  end

  always_comb begin
    key_state = '0;
    for (int p = 0; p < 16; p++) key_state[key_of(4'(p))] = pos_state[p];
  end

  // Column c of the pending mask gets cycle c of the row period, which keeps
  // pushes to one per cycle in ascending column order.
  assign push_col  = settle_ctr[1:0];
  assign push_slot = running && (int'(settle_ctr) < 4);
  assign push_now  = push_slot && chg_mask[push_col];
  assign push_pos  = {chg_row, push_col};
  assign push_data = {pos_state[push_pos], 3'b000, key_of(push_pos)};

  keypad_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .s_tvalid (push_now),
    .s_tready (fifo_ready),
    .s_tdata  (push_data),
    .m_tvalid (event_valid),
    .m_tready (event_ready),
    .m_tdata  (fifo_head)
  );

  assign key_event = event_valid ? fifo_head : 8'hFF;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      overflow <= 1'b0;
    end else if (push_now && !fifo_ready) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner

module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_in;
  logic [3:0]  row_out;
  logic [3:0]  col_in;
  logic        event_valid;
  logic        event_ready;
  logic [7:0]  key_event;
  logic [15:0] key_state;
  logic        overflow;

  // held[r*4+c] = physical key at row r, column c is down
  logic [15:0] held;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  exp_b;

  always #5 clk = ~clk;

  keypad_scanner dut (
    .clk_in      (clk),
    .rst_in      (rst_in),
    .row_out     (row_out),
    .col_in      (col_in),
    .event_valid (event_valid),
    .event_ready (event_ready),
    .key_event   (key_event),
    .key_state   (key_state),
    .overflow    (overflow)
  );

  // Passive keypad matrix: a held key pulls its column low while its row is driven.
  always_comb begin
    col_in = 4'hF;
    case (row_out)
      4'b1110: col_in = ~held[3:0];
      4'b1101: col_in = ~held[7:4];
      4'b1011: col_in = ~held[11:8];
      4'b0111: col_in = ~held[15:12];
      default: col_in = 4'hF;
    endcase
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns on the first cycle of a row-0 period.
  task automatic wait_row0();
    logic [3:0] prev;
    bit found;
    found = 0;
    prev = row_out;
    for (int i = 0; i < 100 && !found; i++) begin
      tick(1);
      if (prev == 4'b0111 && row_out == 4'b1110) found = 1;
      prev = row_out;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL wait_row0 row_out=%b want 1110 following 0111", row_out);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    rst_in = 1'b1;
    held = '0;
    event_ready = 1'b1;
    tick(3);
    tests_run++;
    if (row_out !== 4'hF) begin tests_failed++; $display("FAIL reset_row got %b want 1111", row_out); end
    tests_run++;
    if (event_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", event_valid); end
    tests_run++;
    if (key_event !== 8'hFF) begin tests_failed++; $display("FAIL reset_event got %h want ff", key_event); end
    tests_run++;
    if (key_state !== 16'h0000) begin tests_failed++; $display("FAIL reset_state got %h want 0000", key_state); end
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got %b want 0", overflow); end
    rst_in = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tick(1);
      exp_row = ~(4'b0001 << ((i / 8) % 4));
      tests_run++;
      if (row_out !== exp_row) begin
        tests_failed++;
        $display("FAIL scan_row cycle %0d got %b want %b", i, row_out, exp_row);
      end
    end
    tests_run++;
    if (event_valid !== 1'b0 || key_state !== 16'h0000) begin
      tests_failed++;
      $display("FAIL idle_scan valid=%b state=%h want 0 0000", event_valid, key_state);
    end
  endtask

  task automatic test_press_release();
    event_ready = 1'b1;
    exp_q.push_back(8'h86);
    held[6] = 1'b1;
    tick(160);
    tests_run++;
    if (key_state !== 16'h0040) begin tests_failed++; $display("FAIL press6_state got %h want 0040", key_state); end
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL press6_event pending %0d want 0", exp_q.size()); end
    exp_q.push_back(8'h06);
    held[6] = 1'b0;
    tick(160);
    tests_run++;
    if (key_state !== 16'h0000) begin tests_failed++; $display("FAIL release6_state got %h want 0000", key_state); end
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL release6_event pending %0d want 0", exp_q.size()); end
  endtask

  task automatic test_bounce();
    wait_row0();
    held[0] = 1'b1;
    tick(64);
    held[0] = 1'b0;
    tick(160);
    tests_run++;
    if (key_state !== 16'h0000) begin tests_failed++; $display("FAIL bounce_state got %h want 0000", key_state); end
    tests_run++;
    if (event_valid !== 1'b0) begin tests_failed++; $display("FAIL bounce_valid got %b want 0", event_valid); end
  endtask

  task automatic test_same_row();
    event_ready = 1'b0;
    wait_row0();
    held[0] = 1'b1;
    held[3] = 1'b1;
    tick(160);
    tests_run++;
    if (event_valid !== 1'b1 || key_event !== 8'h81) begin
      tests_failed++;
      $display("FAIL same_row_head valid=%b got %h want 1 81", event_valid, key_event);
    end
    tests_run++;
    if (key_state !== 16'h1002) begin tests_failed++; $display("FAIL same_row_state got %h want 1002", key_state); end
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h8C);
    event_ready = 1'b1;
    tick(4);
    tests_run++;
    if (exp_q.size() != 0 || event_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL same_row_drain pending %0d valid %b want 0 0", exp_q.size(), event_valid);
    end
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h0C);
    held[0] = 1'b0;
    held[3] = 1'b0;
    tick(160);
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL same_row_release pending %0d want 0", exp_q.size()); end
  endtask

  task automatic test_overflow();
    event_ready = 1'b0;
    wait_row0();
    held[0]  = 1'b1;
    held[1]  = 1'b1;
    held[4]  = 1'b1;
    held[8]  = 1'b1;
    held[12] = 1'b1;
    tick(160);
    tests_run++;
    if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag got %b want 1", overflow); end
    tests_run++;
    if (key_state !== 16'h0496) begin tests_failed++; $display("FAIL ovf_state got %h want 0496", key_state); end
    tests_run++;
    if (key_event !== 8'h81) begin tests_failed++; $display("FAIL ovf_head got %h want 81", key_event); end
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h82);
    exp_q.push_back(8'h84);
    exp_q.push_back(8'h87);
    event_ready = 1'b1;
    tick(8);
    tests_run++;
    if (exp_q.size() != 0 || event_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_drain pending %0d valid %b want 0 0", exp_q.size(), event_valid);
    end
    wait_row0();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h07);
    exp_q.push_back(8'h0A);
    held = '0;
    tick(160);
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL ovf_release pending %0d want 0", exp_q.size()); end
    tests_run++;
    if (overflow !== 1'b1 || key_state !== 16'h0000) begin
      tests_failed++;
      $display("FAIL ovf_sticky ovf=%b state=%h want 1 0000", overflow, key_state);
    end
  endtask

  task automatic test_reset_midway();
    event_ready = 1'b1;
    wait_row0();
    held[5] = 1'b1;
    tick(64);
    rst_in = 1'b1;
    tick(1);
    tests_run++;
    if (row_out !== 4'hF || event_valid !== 1'b0 || key_state !== 16'h0000 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset row=%b valid=%b state=%h ovf=%b want 1111 0 0000 0",
               row_out, event_valid, key_state, overflow);
    end
    tick(1);
    rst_in = 1'b0;
    tick(1);
    tests_run++;
    if (row_out !== 4'b1110) begin tests_failed++; $display("FAIL restart_row got %b want 1110", row_out); end
    exp_q.push_back(8'h85);
    tick(59);
    tests_run++;
    if (key_state !== 16'h0000 || exp_q.size() != 1) begin
      tests_failed++;
      $display("FAIL restart_early state=%h pending=%0d want 0000 1", key_state, exp_q.size());
    end
    tick(40);
    tests_run++;
    if (key_state !== 16'h0020 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL restart_event state=%h pending=%0d want 0020 0", key_state, exp_q.size());
    end
    exp_q.push_back(8'h05);
    held[5] = 1'b0;
    tick(160);
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL restart_release pending %0d want 0", exp_q.size()); end
  endtask

  initial begin
    rst_in = 1'b1;
    held = '0;
    event_ready = 1'b1;
    // Scoreboard: every handshaken byte must match the oldest expected event.
    fork
      forever begin
        @(negedge clk);
        if (!rst_in && event_valid && event_ready) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_event got %h want none", key_event);
          end else begin
            exp_b = exp_q.pop_front();
            if (key_event !== exp_b) begin
              tests_failed++;
              $display("FAIL event_byte got %h want %h", key_event, exp_b);
            end
          end
        end
      end
    join_none
    test_reset();
    test_press_release();
    test_bounce();
    test_same_row();
    test_overflow();
    test_reset_midway();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
